// File: rtl/accel_reg_engine.sv
// Accelerator register bank: NUM_REGS data words plus CTRL/STATUS/RESULT,
// zero-wait-state slave port, and a sequential summing engine with interrupt.
module accel_reg_engine #(
  parameter int unsigned NUM_REGS  = 16,
  parameter int unsigned ADDR_BITS = 16
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  trans,
  input  logic [29:0] address,
  input  logic [3:0]  bl,
  input  logic        we,
  input  logic        ce,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic [1:0]  resp,
  output logic        ready,
  output logic        irq
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_BITS-1:0] A_CTRL = ADDR_BITS'(NUM_REGS);
  localparam logic [ADDR_BITS-1:0] A_STAT = ADDR_BITS'(NUM_REGS + 1);
  localparam logic [ADDR_BITS-1:0] A_RES  = ADDR_BITS'(NUM_REGS + 2);
  localparam logic [8:0]           NUM_REGS_9 = 9'(NUM_REGS);
  localparam logic [1:0]           RESP_OKAY = 2'b00;
  localparam logic [1:0]           RESP_ERR  = 2'b01;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e             state_q, state_d;
  logic [31:0]        regs_q [NUM_REGS];
  logic [31:0]        regs_d [NUM_REGS];
  logic [7:0]         count_q, count_d;
  logic               irq_en_q, irq_en_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [31:0]        acc_q, acc_d;
  logic [7:0]         idx_q, idx_d;
  logic [31:0]        result_q, result_d;
  logic [31:0]        read_data_q, read_data_d;
  logic [1:0]         resp_q, resp_d;
  logic               irq_q, irq_d;
  logic               pw_data_q, pw_data_d;
  logic               pw_ctrl_q, pw_ctrl_d;
  logic [IDX_W-1:0]   pw_idx_q, pw_idx_d;
  logic [3:0]         pw_bl_q, pw_bl_d;

  logic               valid_c;
  logic [ADDR_BITS-1:0] addr_c;
  logic [31:0]        wr_merged_c;
  logic [31:0]        sum_c;
  logic               start_c;
  logic               clear_c;
  logic               unused_c;

  assign valid_c  = trans[1] & ce;
  assign addr_c   = address[ADDR_BITS-1:0];
  assign unused_c = ^{trans[0], address[29:ADDR_BITS]};

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  lanes);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = lanes[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return r;
  endfunction

  // Data-phase commit, engine step, then address-phase decode using next state
  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    count_d     = count_q;
    irq_en_d    = irq_en_q;
    done_d      = done_q;
    err_d       = err_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    result_d    = result_q;
    read_data_d = read_data_q;
    resp_d      = resp_q;
    pw_data_d   = 1'b0;
    pw_ctrl_d   = 1'b0;
    pw_idx_d    = pw_idx_q;
    pw_bl_d     = bl;

    wr_merged_c = lane_merge(regs_q[pw_idx_q], write_data, pw_bl_q);
    sum_c       = acc_q + regs_q[IDX_W'(idx_q)];
    start_c     = pw_ctrl_q & write_data[0];
    clear_c     = pw_ctrl_q & write_data[1];

    if (pw_data_q) begin
      regs_d[pw_idx_q] = wr_merged_c;
    end
    if (pw_ctrl_q) begin
      if (pw_bl_q[0]) irq_en_d = write_data[2];
      if (pw_bl_q[1] && (state_q == S_IDLE)) count_d = write_data[15:8];
    end

    if (clear_c) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start_c) begin
          if ((count_d != 8'd0) && ({1'b0, count_d} <= NUM_REGS_9)) begin
            state_d = S_RUN;
            acc_d   = 32'd0;
            idx_d   = 8'd0;
            done_d  = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        acc_d = sum_c;
        idx_d = idx_q + 8'd1;
        if (start_c) err_d = 1'b1;
        // Completion is applied after clear so it always wins
        if (idx_q == (count_q - 8'd1)) begin
          result_d = sum_c;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
    endcase

    if (valid_c) begin
      resp_d = RESP_OKAY;
      if (we) begin
        if (addr_c < A_CTRL) begin
          if (state_d == S_RUN) begin
            resp_d = RESP_ERR;
          end else begin
            pw_data_d = 1'b1;
            pw_idx_d  = IDX_W'(addr_c);
          end
        end else if (addr_c == A_CTRL) begin
          pw_ctrl_d = 1'b1;
        end else begin
          resp_d = RESP_ERR;
        end
      end else begin
        if (addr_c < A_CTRL) begin
          read_data_d = regs_q[IDX_W'(addr_c)];
          if (pw_data_q && (pw_idx_q == IDX_W'(addr_c))) begin
            read_data_d = wr_merged_c;
          end
        end else if (addr_c == A_CTRL) begin
          read_data_d = {16'd0, count_q, 5'd0, irq_en_q, 2'd0};
        end else if (addr_c == A_STAT) begin
          read_data_d = {29'd0, err_q, done_q, (state_q == S_RUN)};
        end else if (addr_c == A_RES) begin
          read_data_d = result_q;
        end else begin
          read_data_d = 32'd0;
          resp_d      = RESP_ERR;
        end
      end
    end

    irq_d = irq_en_d & (done_d | err_d);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 32'd0;
      count_q     <= 8'd0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      acc_q       <= 32'd0;
      idx_q       <= 8'd0;
      result_q    <= 32'd0;
      read_data_q <= 32'd0;
      resp_q      <= RESP_OKAY;
      irq_q       <= 1'b0;
      pw_data_q   <= 1'b0;
      pw_ctrl_q   <= 1'b0;
      pw_idx_q    <= '0;
      pw_bl_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      regs_q      <= regs_d;
      count_q     <= count_d;
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      err_q       <= err_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      result_q    <= result_d;
      read_data_q <= read_data_d;
      resp_q      <= resp_d;
      irq_q       <= irq_d;
      pw_data_q   <= pw_data_d;
      pw_ctrl_q   <= pw_ctrl_d;
      pw_idx_q    <= pw_idx_d;
      pw_bl_q     <= pw_bl_d;
    end
  end

  assign read_data = read_data_q;
  assign resp      = resp_q;
  assign irq       = irq_q;
  assign ready     = 1'b1;

endmodule

// File: tb/tb_accel_reg_engine.sv
// Directed bench for accel_reg_engine: pipelined vector table plus
// hand-written engine sequences (sum, errors, boundaries, mid-run reset).
module tb_accel_reg_engine;

  logic        clock = 1'b0;
  logic        resetn;
  logic [1:0]  trans;
  logic [29:0] address;
  logic [3:0]  bl;
  logic        we;
  logic        ce;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic [1:0]  resp;
  logic        ready;
  logic        irq;

  accel_reg_engine #(.NUM_REGS(16), .ADDR_BITS(16)) dut (
    .clock(clock), .resetn(resetn), .trans(trans), .address(address),
    .bl(bl), .we(we), .ce(ce), .write_data(write_data),
    .read_data(read_data), .resp(resp), .ready(ready), .irq(irq)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic        w;
    logic [29:0] a;
    logic [3:0]  b;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [1:0]  exp_rs;
    logic        chk_rd;
  } vec_t;

  localparam int NV = 17;
  vec_t vt [NV];

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;
  logic [1:0]  rs;
  logic [31:0] exp_sum;
  logic [31:0] val;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic access(input logic w, input logic [29:0] a, input logic [3:0] b,
                        input logic [31:0] wd, output logic [31:0] rdo, output logic [1:0] rso);
    @(negedge clock);
    trans = 2'b10; ce = 1'b1; we = w; address = a; bl = b;
    @(negedge clock);
    trans = 2'b00; ce = 1'b0; we = 1'b0; write_data = wd;
    rdo = read_data; rso = resp;
  endtask

  initial begin
    resetn = 1'b0; trans = 2'b00; address = '0; bl = 4'h0; we = 1'b0; ce = 1'b0;
    write_data = '0;

    vt[0]  = '{1'b1, 1'b1, 30'd3,       4'hF, 32'hDEADBEEF, 32'h0,        2'b00, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 30'd3,       4'hF, 32'h0,        32'hDEADBEEF, 2'b00, 1'b1};
    vt[2]  = '{1'b1, 1'b1, 30'd3,       4'h1, 32'h000000AA, 32'h0,        2'b00, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 30'd3,       4'hF, 32'h0,        32'hDEADBEAA, 2'b00, 1'b1};
    vt[4]  = '{1'b1, 1'b0, 30'd3,       4'hF, 32'h0,        32'hDEADBEAA, 2'b00, 1'b1};
    vt[5]  = '{1'b1, 1'b1, 30'd5,       4'hF, 32'h12345678, 32'h0,        2'b00, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 30'd5,       4'hF, 32'h0,        32'h12345678, 2'b00, 1'b1};
    vt[7]  = '{1'b1, 1'b0, 30'd19,      4'hF, 32'h0,        32'h0,        2'b01, 1'b1};
    vt[8]  = '{1'b1, 1'b1, 30'd18,      4'hF, 32'h00000055, 32'h0,        2'b01, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 30'd18,      4'hF, 32'h0,        32'h0,        2'b00, 1'b1};
    vt[10] = '{1'b1, 1'b1, 30'd2,       4'h6, 32'hAABBCCDD, 32'h0,        2'b00, 1'b0};
    vt[11] = '{1'b1, 1'b0, 30'd2,       4'hF, 32'h0,        32'h00BBCC00, 2'b00, 1'b1};
    vt[12] = '{1'b1, 1'b1, 30'd17,      4'hF, 32'h00000001, 32'h0,        2'b01, 1'b0};
    vt[13] = '{1'b1, 1'b0, 30'd16,      4'hF, 32'h0,        32'h0,        2'b00, 1'b1};
    vt[14] = '{1'b1, 1'b0, 30'h0001_0003, 4'hF, 32'h0,      32'hDEADBEAA, 2'b00, 1'b1};
    vt[15] = '{1'b1, 1'b0, 30'h0000_FFFF, 4'hF, 32'h0,      32'h0,        2'b01, 1'b1};
    vt[16] = '{1'b0, 1'b0, 30'd3,       4'hF, 32'h0,        32'h0,        2'b01, 1'b1};

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_rdata", read_data, 32'h0);
    chk("rst_resp", 32'(resp), 32'h0);
    chk("rst_ready", 32'(ready), 32'h1);
    chk("rst_irq", 32'(irq), 32'h0);
    resetn = 1'b1;

    // Back-to-back vector table: write data follows its address by one cycle
    for (int k = 0; k <= NV; k++) begin
      @(negedge clock);
      if (k > 0) begin
        if (vt[k-1].chk_rd) chk($sformatf("vec%0d_rdata", k-1), read_data, vt[k-1].exp_rd);
        chk($sformatf("vec%0d_resp", k-1), 32'(resp), 32'(vt[k-1].exp_rs));
        write_data = vt[k-1].wd;
      end
      if (k < NV) begin
        trans = vt[k].v ? 2'b10 : 2'b01; ce = 1'b1; we = vt[k].w;
        address = vt[k].a; bl = vt[k].b;
      end else begin
        trans = 2'b00; ce = 1'b0; we = 1'b0;
      end
    end
    @(negedge clock);

    // Sum with wrap: 1+2+3+0xFFFFFFFF = 5
    access(1'b1, 30'd0, 4'hF, 32'd1, rd, rs);
    access(1'b1, 30'd1, 4'hF, 32'd2, rd, rs);
    access(1'b1, 30'd2, 4'hF, 32'd3, rd, rs);
    access(1'b1, 30'd3, 4'hF, 32'hFFFFFFFF, rd, rs);
    access(1'b1, 30'd16, 4'hF, 32'h405, rd, rs);
    chk("start_resp", 32'(rs), 32'h0);
    for (int j = 0; j < 6; j++) begin
      @(negedge clock);
      if (j > 0) chk($sformatf("run_status%0d", j), read_data, (j < 5) ? 32'h1 : 32'h2);
      chk($sformatf("run_irq%0d", j), 32'(irq), (j >= 4) ? 32'h1 : 32'h0);
      trans = 2'b10; ce = 1'b1; we = 1'b0; address = 30'd17;
    end
    @(negedge clock);
    trans = 2'b00; ce = 1'b0;
    access(1'b0, 30'd18, 4'hF, 32'h0, rd, rs);
    chk("sum_result", rd, 32'h5);
    access(1'b0, 30'd16, 4'hF, 32'h0, rd, rs);
    chk("ctrl_read", rd, 32'h404);
    access(1'b1, 30'd16, 4'hF, 32'h406, rd, rs);
    @(negedge clock);
    chk("clear_irq", 32'(irq), 32'h0);
    access(1'b0, 30'd17, 4'hF, 32'h0, rd, rs);
    chk("clear_status", rd, 32'h0);

    // Start with irq_en=0, then start while busy sets err and irq_en, then write while busy
    access(1'b1, 30'd16, 4'hF, 32'h401, rd, rs);
    access(1'b1, 30'd16, 4'hF, 32'h405, rd, rs);
    chk("busy_start_resp", 32'(rs), 32'h0);
    access(1'b1, 30'd0, 4'hF, 32'h99, rd, rs);
    chk("busy_write_resp", 32'(rs), 32'h1);
    access(1'b0, 30'd17, 4'hF, 32'h0, rd, rs);
    chk("busy_err_status", rd, 32'h6);
    chk("busy_err_irq", 32'(irq), 32'h1);
    access(1'b0, 30'd18, 4'hF, 32'h0, rd, rs);
    chk("busy_err_result", rd, 32'h5);
    access(1'b0, 30'd0, 4'hF, 32'h0, rd, rs);
    chk("busy_write_reg0", rd, 32'h1);
    access(1'b1, 30'd16, 4'hF, 32'h006, rd, rs);

    // Start with count=0
    access(1'b1, 30'd16, 4'hF, 32'h005, rd, rs);
    access(1'b0, 30'd17, 4'hF, 32'h0, rd, rs);
    chk("cnt0_status", rd, 32'h4);
    chk("cnt0_irq", 32'(irq), 32'h1);
    access(1'b1, 30'd16, 4'hF, 32'h006, rd, rs);

    // count=N, with clear committing in the completion cycle
    exp_sum = 32'h0;
    for (int i = 0; i < 16; i++) begin
      val = 32'(i + 1) * 32'h1111_1111;
      exp_sum = exp_sum + val;
      access(1'b1, 30'(i), 4'hF, val, rd, rs);
    end
    access(1'b1, 30'd16, 4'hF, 32'h1005, rd, rs);
    repeat (15) @(negedge clock);
    trans = 2'b10; ce = 1'b1; we = 1'b1; address = 30'd16; bl = 4'hF;
    @(negedge clock);
    trans = 2'b00; ce = 1'b0; we = 1'b0; write_data = 32'h1006;
    access(1'b0, 30'd17, 4'hF, 32'h0, rd, rs);
    chk("full_clear_status", rd, 32'h2);
    chk("full_irq", 32'(irq), 32'h1);
    access(1'b0, 30'd18, 4'hF, 32'h0, rd, rs);
    chk("full_result", rd, exp_sum);

    // Reset mid-run
    access(1'b1, 30'd16, 4'hF, 32'h1005, rd, rs);
    repeat (3) @(negedge clock);
    #2 resetn = 1'b0;
    @(negedge clock);
    chk("mid_rst_rdata", read_data, 32'h0);
    chk("mid_rst_resp", 32'(resp), 32'h0);
    chk("mid_rst_irq", 32'(irq), 32'h0);
    chk("mid_rst_ready", 32'(ready), 32'h1);
    resetn = 1'b1;
    access(1'b0, 30'd3, 4'hF, 32'h0, rd, rs);
    chk("mid_rst_reg3", rd, 32'h0);
    access(1'b0, 30'd15, 4'hF, 32'h0, rd, rs);
    chk("mid_rst_reg15", rd, 32'h0);
    access(1'b0, 30'd16, 4'hF, 32'h0, rd, rs);
    chk("mid_rst_ctrl", rd, 32'h0);
    access(1'b0, 30'd17, 4'hF, 32'h0, rd, rs);
    chk("mid_rst_status", rd, 32'h0);
    access(1'b0, 30'd18, 4'hF, 32'h0, rd, rs);
    chk("mid_rst_result", rd, 32'h0);
    access(1'b1, 30'd0, 4'hF, 32'd7, rd, rs);
    access(1'b1, 30'd1, 4'hF, 32'd8, rd, rs);
    access(1'b1, 30'd16, 4'hF, 32'h205, rd, rs);
    repeat (4) @(negedge clock);
    access(1'b0, 30'd17, 4'hF, 32'h0, rd, rs);
    chk("post_rst_status", rd, 32'h2);
    access(1'b0, 30'd18, 4'hF, 32'h0, rd, rs);
    chk("post_rst_result", rd, 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
